jtcps15_dspmbox: RTL and testbench
==================================

Name: jtcps15_dspmbox

Overview:
- Parametrised CPU-to-DSP16 command mailbox for the QSound section.
- Successor to the single-entry Z80→DSP latch. It adds a FIFO of DEPTH commands, configurable data/address widths, a flush, and overflow reporting.
- Z80 writes data MSB, data LSB, then address; the address write commits the entry.
- DSP side sees irq and reads each entry in two PIDS strobes: address first, then data.

Parameters:
- DW, 16, data word width (multiple of 8, 8..32).
- AW, 8, command address width (1..DW).
- PTRW, 2, FIFO pointer width; DEPTH = 2**PTRW (PTRW ≥ 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr  in  1  one-cycle CPU write strobe
- wsel  in  2  0 = data high byte, 1 = data low byte (DW=16; for other DW, byte lanes index from MSB), 2 = address + commit, 3 = ignored
- wdata  in  8  CPU write byte
- flush  in  1  clear FIFO and DSP handshake (staging kept)
- full  out  1  FIFO full
- level  out  PTRW+1  entries stored
- ovf  out  1  sticky: commit dropped while full
- clr_ovf  in  1  clears ovf
- drop_cnt  out  8  dropped-commit counter (see Optional Feature)
- pids_n  in  1  DSP parallel input strobe, active low
- pbus  out  DW  DSP parallel bus input data
- irq  out  1  DSP interrupt request

Behaviour:
- Reset values:
  - Outputs: full=0, level=0, ovf=0, irq=0, drop_cnt=0, pbus=0.
  - Internal: staging regs 0, pointers 0, state IDLE, last_pids_n=1.
- Staging:
  - wr with wsel 0/1 loads the addressed byte of stage_data.
  - wr with wsel 2 loads stage_addr = wdata[AW-1:0] (zero-extended if AW>8).
  - In the same cycle, {wdata addr, stage_data} is pushed if not full.
  - If full, the push is dropped, ovf is set and drop_cnt increments.
  - Staging is not cleared by commit; only rst clears it.
- FIFO:
  - Circular, pointers wrap mod DEPTH.
  - full = (level == DEPTH).
  - level and full are registered; they update the cycle after push/pop.
- PIDS edge: pids_rise = pids_n & ~last_pids_n, where last_pids_n is registered every cycle.
- State machine:
  - IDLE: irq=0; pbus=0. Enters REQ when level≠0.
  - REQ: irq=1; pbus = head address, zero-extended. On pids_rise enters DATA with irq=0.
  - DATA: irq=0; pbus = head data. On pids_rise pops the head and enters GAP.
  - GAP: one cycle, irq=0, pbus=0, then IDLE. This guarantees irq is low ≥2 cycles between entries.
  - pids_rise in IDLE/GAP is ignored.
- Timing: irq rises 2 cycles after the committing wr when the FIFO was empty and the state was IDLE. Cycle 1 updates level; cycle 2 is REQ.
- Simultaneous pop and commit while full: the pop is applied first and the commit is accepted; level stays DEPTH.
- clr_ovf and a dropped commit in the same cycle: ovf ends 1.
- flush: pointers and level go to 0, state to IDLE, irq to 0. A commit in the same cycle is discarded without setting ovf.
- Synchronous rst mid-transfer aborts everything in one cycle to the reset values.

Optional Feature:
- Macro: JTCPS15_MBOX_DROPCNT_EN.
- Defined: drop_cnt is an 8-bit counter of dropped commits. It saturates at 255 and is cleared by rst and clr_ovf.
- Undefined: drop_cnt is tied to 0 and no counter logic is built. ovf still works.

Test Plan:
- Basic transfer: rst, then write wsel0=0x12, wsel1=0x34, wsel2=0x56. Expect:
  - irq=1 two cycles later with pbus=0x0056.
  - After pulsing pids_n low then high: irq=0, pbus=0x1234.
  - After a second pulse: level=0, one GAP cycle, then IDLE.
- Fill/overflow, DEPTH=4: commit 5 entries with no DSP reads. Expect:
  - full=1, level=4, ovf=1.
  - drop_cnt=1 with JTCPS15_MBOX_DROPCNT_EN, 0 without.
  - Reads return only the first 4 entries, in order.
- Back-to-back drain: commit 3 entries, then service each irq. Expect:
  - irq deasserted ≥2 cycles between entries.
  - Addresses and data arrive in commit order; pointers wrap correctly after a further 4 commits.
- Simultaneous pop and commit at full: expect the commit accepted, level stays 4, ovf stays 0.
- Flush mid-transfer: assert flush while in DATA. Expect:
  - Next cycle irq=0, level=0, pbus=0.
  - A later pids pulse is ignored.
  - A new commit restarts normally.
- Reset mid-transfer: assert rst while in REQ with 2 entries stored. Expect all outputs at reset values next cycle; the staging registers read back as 0 via a following commit.

Source files
------------

// File: rtl/jtcps15_dspmbox_if.sv
`default_nettype none
// ============================================================================
// Module   : jtcps15_dspmbox_if
// Brief    : CPU write port, DSP PIDS read port and status for the mailbox.
// Revision : 1.0 - initial release
// ============================================================================
interface jtcps15_dspmbox_if #(
  parameter int DW   = 16,
  parameter int PTRW = 2
);
  logic            wr;
  logic [1:0]      wsel;
  logic [7:0]      wdata;
  logic            flush;
  logic            full;
  logic [PTRW:0]   level;
  logic            ovf;
  logic            clr_ovf;
  logic [7:0]      drop_cnt;
  logic            pids_n;
  logic [DW-1:0]   pbus;
  logic            irq;

  modport master (
    output wr, wsel, wdata, flush, clr_ovf, pids_n,
    input  full, level, ovf, drop_cnt, pbus, irq
  );

  modport slave (
    input  wr, wsel, wdata, flush, clr_ovf, pids_n,
    output full, level, ovf, drop_cnt, pbus, irq
  );
endinterface
`default_nettype wire

// File: rtl/jtcps15_dspmbox.sv
`default_nettype none
// ============================================================================
// Module   : jtcps15_dspmbox
// Brief    : Z80-to-DSP16 command mailbox with a DEPTH-entry FIFO, flush and
//            overflow reporting. Define JTCPS15_MBOX_DROPCNT_EN to build the
//            saturating dropped-commit counter.
// Revision : 1.0 - initial release
// ============================================================================
module jtcps15_dspmbox #(
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int PTRW = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  jtcps15_dspmbox_if.slave       mbox
);
  localparam int c_DEPTH = 1 << PTRW;
  localparam int c_NB    = DW / 8;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_DATA = 2'd2;
  localparam logic [1:0] c_GAP  = 2'd3;

  logic [DW-1:0]   r_stage_data;
  logic [AW-1:0]   r_stage_addr;
  logic [AW-1:0]   r_addr_mem [c_DEPTH];
  logic [DW-1:0]   r_data_mem [c_DEPTH];
  logic [PTRW-1:0] r_wptr, r_rptr;
  logic [PTRW:0]   r_level;
  logic            r_full;
  logic            r_ovf;
  logic            r_last_pids_n;
  logic [1:0]      r_state, w_state_nxt;

  logic            w_stage_wr, w_commit, w_push, w_pop, w_drop, w_pids_rise;
  logic [AW-1:0]   w_new_addr;
  logic [PTRW:0]   w_level_nxt;
  logic            w_irq;
  logic [DW-1:0]   w_pbus;

  assign w_stage_wr  = mbox.wr && !mbox.wsel[1];
  assign w_commit    = mbox.wr && (mbox.wsel == 2'd2) && !mbox.flush;
  assign w_new_addr  = AW'(mbox.wdata);
  assign w_pids_rise = mbox.pids_n && !r_last_pids_n;
  assign w_pop       = (r_state == c_DATA) && w_pids_rise && !mbox.flush;
  // A pop in the same cycle frees a slot, so a commit at full still lands.
  assign w_push      = w_commit && (!r_full || w_pop);
  assign w_drop      = w_commit && r_full && !w_pop;
  assign w_level_nxt = r_level + (PTRW+1)'(w_push) - (PTRW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage_data <= '0;
      r_stage_addr <= '0;
    end else begin
      for (int b = 0; b < c_NB; b++) begin
        if (w_stage_wr && (b == int'(mbox.wsel[0])))
          r_stage_data[DW-1-8*b -: 8] <= mbox.wdata;
      end
      if (mbox.wr && (mbox.wsel == 2'd2))
        r_stage_addr <= w_new_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= w_new_addr;
      r_data_mem[r_wptr] <= r_stage_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || mbox.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (PTRW+1)'(c_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf         <= 1'b0;
      r_last_pids_n <= 1'b1;
    end else begin
      r_last_pids_n <= mbox.pids_n;
      // A drop in the same cycle as clr_ovf keeps the flag set.
      if (w_drop)            r_ovf <= 1'b1;
      else if (mbox.clr_ovf) r_ovf <= 1'b0;
    end
  end

`ifdef JTCPS15_MBOX_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_drop_cnt <= 8'd0;
    else if (mbox.clr_ovf)
      r_drop_cnt <= {7'd0, w_drop};
    else if (w_drop && (r_drop_cnt != 8'hFF))
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign mbox.drop_cnt = r_drop_cnt;
`else
  assign mbox.drop_cnt = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (r_level != '0) w_state_nxt = c_REQ;
      c_REQ:   if (w_pids_rise)   w_state_nxt = c_DATA;
      c_DATA:  if (w_pids_rise)   w_state_nxt = c_GAP;
      c_GAP:   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
    if (mbox.flush) w_state_nxt = c_IDLE;
  end

  always_comb begin
    w_irq  = 1'b0;
    w_pbus = '0;
    case (r_state)
      c_REQ: begin
        w_irq  = 1'b1;
        w_pbus = DW'(r_addr_mem[r_rptr]);
      end
      c_DATA:  w_pbus = r_data_mem[r_rptr];
      default: ;
    endcase
  end

  assign mbox.irq   = w_irq;
  assign mbox.pbus  = w_pbus;
  assign mbox.full  = r_full;
  assign mbox.level = r_level;
  assign mbox.ovf   = r_ovf;

  logic w_unused;
  assign w_unused = ^r_stage_addr;
endmodule
`default_nettype wire

// File: tb/tb_jtcps15_dspmbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtcps15_dspmbox
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized rounds scored against a queue model of the mailbox.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtcps15_dspmbox;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int PTRW  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtcps15_dspmbox_if #(.DW(DW), .PTRW(PTRW)) mbox ();

  jtcps15_dspmbox #(.DW(DW), .AW(AW), .PTRW(PTRW)) dut (
    .clk  (clk),
    .rst  (rst),
    .mbox (mbox)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  wsel;
    logic [7:0]  wdata;
    logic        pids_n;
    logic        e_irq;
    logic [15:0] e_pbus;
    logic [2:0]  e_level;
  } vec_t;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } ent_t;

  vec_t vecs [10];
  ent_t q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [1:0] sel, input logic [7:0] d);
    mbox.wr    = 1'b1;
    mbox.wsel  = sel;
    mbox.wdata = d;
    cyc();
    mbox.wr = 1'b0;
  endtask

  task automatic commit(input logic [7:0] a, input logic [15:0] d);
    wr_byte(2'd0, d[15:8]);
    wr_byte(2'd1, d[7:0]);
    wr_byte(2'd2, a);
  endtask

  task automatic pulse();
    mbox.pids_n = 1'b0;
    cyc();
    mbox.pids_n = 1'b1;
    cyc();
  endtask

  task automatic wait_irq(input string nm);
    int t = 0;
    while (mbox.irq !== 1'b1 && t < 50) begin
      cyc();
      t++;
    end
    chk({nm, "_irq_wait"}, 32'(mbox.irq), 32'd1);
  endtask

  // Services one irq and checks address, data and the low-irq gap after it.
  task automatic read_entry(input string nm, input logic [7:0] ea, input logic [15:0] ed);
    wait_irq(nm);
    chk({nm, "_addr"}, 32'(mbox.pbus), 32'(ea));
    pulse();
    chk({nm, "_irq_in_data"}, 32'(mbox.irq), 32'd0);
    chk({nm, "_data"}, 32'(mbox.pbus), 32'(ed));
    pulse();
    chk({nm, "_irq_gap1"}, 32'(mbox.irq), 32'd0);
    cyc();
    chk({nm, "_irq_gap2"}, 32'(mbox.irq), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_full"},  32'(mbox.full),     32'd0);
    chk({nm, "_level"}, 32'(mbox.level),    32'd0);
    chk({nm, "_ovf"},   32'(mbox.ovf),      32'd0);
    chk({nm, "_irq"},   32'(mbox.irq),      32'd0);
    chk({nm, "_drop"},  32'(mbox.drop_cnt), 32'd0);
    chk({nm, "_pbus"},  32'(mbox.pbus),     32'd0);
  endtask

  function automatic logic [7:0] exp_drops(input int n);
`ifdef JTCPS15_MBOX_DROPCNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n < 0) ? 8'd1 : 8'd0;
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] m_stage;
    int drops;
    int n;
    logic [7:0] a;
    ent_t e;

    vecs[0] = '{1'b1, 2'd0, 8'h12, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[1] = '{1'b1, 2'd1, 8'h34, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[2] = '{1'b1, 2'd2, 8'h56, 1'b1, 1'b0, 16'h0000, 3'd1};
    vecs[3] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 16'h0056, 3'd1};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 16'h0056, 3'd1};
    vecs[5] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 16'h1234, 3'd1};
    vecs[6] = '{1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 16'h1234, 3'd1};
    vecs[7] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[8] = '{1'b1, 2'd3, 8'hEE, 1'b1, 1'b0, 16'h0000, 3'd0};
    vecs[9] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 16'h0000, 3'd0};

    rst = 1'b1;
    mbox.wr = 1'b0; mbox.wsel = 2'd0; mbox.wdata = 8'd0;
    mbox.flush = 1'b0; mbox.clr_ovf = 1'b0; mbox.pids_n = 1'b1;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Basic transfer, one record per clock
    for (int i = 0; i < 10; i++) begin
      mbox.wr = vecs[i].wr; mbox.wsel = vecs[i].wsel;
      mbox.wdata = vecs[i].wdata; mbox.pids_n = vecs[i].pids_n;
      cyc();
      chk($sformatf("vec%0d_irq", i),   32'(mbox.irq),   32'(vecs[i].e_irq));
      chk($sformatf("vec%0d_pbus", i),  32'(mbox.pbus),  32'(vecs[i].e_pbus));
      chk($sformatf("vec%0d_level", i), 32'(mbox.level), 32'(vecs[i].e_level));
    end
    mbox.wr = 1'b0; mbox.pids_n = 1'b1;

    // Fill and overflow
    for (int i = 0; i < 5; i++) commit(8'(8'h10 + i), 16'(16'hA000 + i));
    cyc();
    chk("ovf_full",  32'(mbox.full),     32'd1);
    chk("ovf_level", 32'(mbox.level),    32'd4);
    chk("ovf_flag",  32'(mbox.ovf),      32'd1);
    chk("ovf_drop",  32'(mbox.drop_cnt), 32'(exp_drops(1)));
    for (int i = 0; i < 4; i++) read_entry($sformatf("ovf_rd%0d", i), 8'(8'h10 + i), 16'(16'hA000 + i));
    repeat (4) cyc();
    chk("ovf_no5th_irq", 32'(mbox.irq),   32'd0);
    chk("ovf_drained",   32'(mbox.level), 32'd0);
    mbox.clr_ovf = 1'b1; cyc(); mbox.clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(mbox.ovf),      32'd0);
    chk("drop_cleared", 32'(mbox.drop_cnt), 32'd0);

    // Back-to-back drain and pointer wrap
    for (int i = 0; i < 3; i++) commit(8'(8'h60 + i), 16'(16'h6000 + 16'h11 * i));
    for (int i = 0; i < 3; i++) read_entry($sformatf("b2b_rd%0d", i), 8'(8'h60 + i), 16'(16'h6000 + 16'h11 * i));
    for (int i = 0; i < 4; i++) commit(8'(8'h70 + i), 16'(16'h7000 + 16'h22 * i));
    for (int i = 0; i < 4; i++) read_entry($sformatf("wrap_rd%0d", i), 8'(8'h70 + i), 16'(16'h7000 + 16'h22 * i));

    // Pop and commit in the same cycle while full
    for (int i = 0; i < 4; i++) commit(8'(8'h20 + i), 16'(16'hB000 + i));
    wait_irq("simul");
    pulse();
    chk("simul_head_data", 32'(mbox.pbus), 32'h0000B000);
    mbox.pids_n = 1'b0; cyc();
    mbox.pids_n = 1'b1;
    wr_byte(2'd2, 8'h30);
    chk("simul_level", 32'(mbox.level), 32'd4);
    chk("simul_full",  32'(mbox.full),  32'd1);
    chk("simul_ovf",   32'(mbox.ovf),   32'd0);
    for (int i = 1; i < 4; i++) read_entry($sformatf("simul_rd%0d", i), 8'(8'h20 + i), 16'(16'hB000 + i));
    read_entry("simul_new", 8'h30, 16'hB003);

    // Flush while in DATA, then commit together with flush
    commit(8'h41, 16'hC0DE);
    wait_irq("flush");
    pulse();
    chk("flush_in_data", 32'(mbox.pbus), 32'h0000C0DE);
    mbox.flush = 1'b1; cyc(); mbox.flush = 1'b0;
    chk("flush_irq",   32'(mbox.irq),   32'd0);
    chk("flush_level", 32'(mbox.level), 32'd0);
    chk("flush_pbus",  32'(mbox.pbus),  32'd0);
    pulse();
    cyc();
    chk("flush_pids_ignored_irq",  32'(mbox.irq),  32'd0);
    chk("flush_pids_ignored_pbus", 32'(mbox.pbus), 32'd0);
    mbox.flush = 1'b1;
    wr_byte(2'd2, 8'h99);
    mbox.flush = 1'b0;
    cyc();
    chk("flush_commit_level", 32'(mbox.level), 32'd0);
    chk("flush_commit_ovf",   32'(mbox.ovf),   32'd0);
    chk("flush_commit_irq",   32'(mbox.irq),   32'd0);
    wr_byte(2'd2, 8'h42);
    chk("restart_pre_irq", 32'(mbox.irq), 32'd0);
    cyc();
    chk("restart_irq_2cyc", 32'(mbox.irq), 32'd1);
    read_entry("restart", 8'h42, 16'hC0DE);

    // Reset while in REQ with two entries stored
    commit(8'h51, 16'h2222);
    commit(8'h52, 16'h3333);
    wait_irq("rstmid");
    chk("rstmid_level", 32'(mbox.level), 32'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk_reset_outputs("rstmid");
    wr_byte(2'd2, 8'h77);
    read_entry("rstmid_stage", 8'h77, 16'h0000);

    // Randomized rounds against the queue model
    m_stage = 16'h0000;
    for (int r = 0; r < 10; r++) begin
      mbox.clr_ovf = 1'b1; cyc(); mbox.clr_ovf = 1'b0;
      drops = 0;
      n = int'($urandom_range(1, 7));
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) != 0) begin
          a = 8'($urandom);
          wr_byte(2'd0, a);
          m_stage[15:8] = a;
        end
        if ($urandom_range(0, 2) != 0) begin
          a = 8'($urandom);
          wr_byte(2'd1, a);
          m_stage[7:0] = a;
        end
        a = 8'($urandom);
        wr_byte(2'd2, a);
        if (q.size() < DEPTH) begin
          e.a = a; e.d = m_stage;
          q.push_back(e);
        end else begin
          drops++;
        end
      end
      cyc();
      chk($sformatf("rnd%0d_level", r), 32'(mbox.level),    32'(q.size()));
      chk($sformatf("rnd%0d_full", r),  32'(mbox.full),     32'(q.size() == DEPTH));
      chk($sformatf("rnd%0d_ovf", r),   32'(mbox.ovf),      32'(drops > 0));
      chk($sformatf("rnd%0d_drop", r),  32'(mbox.drop_cnt), 32'(exp_drops(drops)));
      while (q.size() > 0) begin
        e = q.pop_front();
        read_entry($sformatf("rnd%0d_rd", r), e.a, e.d);
      end
      chk($sformatf("rnd%0d_empty", r), 32'(mbox.level), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
